// File: rtl/renkon_pkg.sv
// Shared renkon types and sizing: field widths, default layer-table depth and
// the per-layer configuration record held in the scheduler's table.
package renkon_pkg;

    localparam int unsigned LWIDTH           = 16;
    localparam int unsigned IMGSIZE          = 16;
    localparam int unsigned RENKON_LAYER_MAX = 8;

    typedef struct packed {
        logic [LWIDTH-1:0]  total_out;
        logic [LWIDTH-1:0]  total_in;
        logic [LWIDTH-1:0]  img_size;
        logic [LWIDTH-1:0]  fil_size;
        logic [IMGSIZE-1:0] in_offset;
        logic [IMGSIZE-1:0] out_offset;
    } layer_cfg_t;

endpackage

// File: rtl/renkon_layer_table.sv
// Layer configuration register file: one synchronous write port, one
// combinational read port. Not reset; entries are undefined until written.
module renkon_layer_table
    import renkon_pkg::*;
#(
    parameter int unsigned LAYER_MAX = RENKON_LAYER_MAX,
    parameter int unsigned LAYERLOG  = 3
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [LAYERLOG-1:0] waddr_i,
    input  layer_cfg_t          wdata_i,
    input  logic [LAYERLOG-1:0] raddr_i,
    output layer_cfg_t          rdata_o
);

    layer_cfg_t mem_q [LAYER_MAX];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/renkon_layer_sched.sv
// Layer sequencer: walks the layer table, issuing one request per layer to the
// core and waiting for its ack. Define RENKON_SCHED_CHAIN_EN to chain offsets.
module renkon_layer_sched
    import renkon_pkg::*;
#(
    parameter int unsigned LAYER_MAX = RENKON_LAYER_MAX,
    parameter int unsigned LAYERLOG  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [LAYERLOG-1:0] cfg_addr,
    input  logic [LWIDTH-1:0]   cfg_total_out,
    input  logic [LWIDTH-1:0]   cfg_total_in,
    input  logic [LWIDTH-1:0]   cfg_img_size,
    input  logic [LWIDTH-1:0]   cfg_fil_size,
    input  logic [IMGSIZE-1:0]  cfg_in_offset,
    input  logic [IMGSIZE-1:0]  cfg_out_offset,
    input  logic                start,
    input  logic [LAYERLOG:0]   num_layers,
    input  logic                abort,
    output logic                req,
    output logic [LWIDTH-1:0]   total_out,
    output logic [LWIDTH-1:0]   total_in,
    output logic [LWIDTH-1:0]   img_size,
    output logic [LWIDTH-1:0]   fil_size,
    output logic [IMGSIZE-1:0]  in_offset,
    output logic [IMGSIZE-1:0]  out_offset,
    input  logic                ack,
    output logic                busy,
    output logic                done,
    output logic [LAYERLOG-1:0] cur_layer
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [LAYERLOG:0]   cnt_q;
    logic [LAYERLOG-1:0] cur_q;
    logic                req_q;
    logic                done_q;
    logic                ack_prev_q;
    layer_cfg_t          par_q;

    layer_cfg_t          wr_cfg;
    layer_cfg_t          rd_cfg;
    layer_cfg_t          issue_cfg;
    logic [LAYERLOG-1:0] rd_addr;
    logic [LAYERLOG:0]   nxt_idx;
    logic [LAYERLOG:0]   num_sat;
    logic                ack_rise;

    assign wr_cfg = '{total_out:  cfg_total_out,
                      total_in:   cfg_total_in,
                      img_size:   cfg_img_size,
                      fil_size:   cfg_fil_size,
                      in_offset:  cfg_in_offset,
                      out_offset: cfg_out_offset};

    renkon_layer_table #(
        .LAYER_MAX (LAYER_MAX),
        .LAYERLOG  (LAYERLOG)
    ) u_table (
        .clk     (clk),
        .we_i    (cfg_we),
        .waddr_i (cfg_addr),
        .wdata_i (wr_cfg),
        .raddr_i (rd_addr),
        .rdata_o (rd_cfg)
    );

    assign nxt_idx  = {1'b0, cur_q} + (LAYERLOG+1)'(1);
    assign num_sat  = (num_layers > (LAYERLOG+1)'(LAYER_MAX)) ? (LAYERLOG+1)'(LAYER_MAX) : num_layers;
    assign rd_addr  = (state_q == S_NEXT) ? nxt_idx[LAYERLOG-1:0] : '0;
    // A held-high ack completes only one layer: act on its rising edge.
    assign ack_rise = ack && !ack_prev_q;

    always_comb begin
        issue_cfg = rd_cfg;
`ifdef RENKON_SCHED_CHAIN_EN
        if (state_q == S_NEXT) begin
            issue_cfg.in_offset = par_q.out_offset;
        end
`endif
    end

    // Parameters and req are registered on the edge entering S_ISSUE, so they
    // are visible during the S_ISSUE cycle itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            ack_prev_q <= 1'b0;
            par_q      <= '0;
        end else begin
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            ack_prev_q <= ack;
            if (abort) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            cnt_q <= num_sat;
                            cur_q <= '0;
                            if (num_sat != '0) begin
                                state_q <= S_ISSUE;
                                req_q   <= 1'b1;
                                par_q   <= issue_cfg;
                            end else begin
                                state_q <= S_NEXT;
                            end
                        end
                    end
                    S_ISSUE: state_q <= S_WAIT;
                    S_WAIT: begin
                        if (ack_rise) begin
                            state_q <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (nxt_idx < cnt_q) begin
                            cur_q   <= nxt_idx[LAYERLOG-1:0];
                            state_q <= S_ISSUE;
                            req_q   <= 1'b1;
                            par_q   <= issue_cfg;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign req        = req_q;
    assign done       = done_q;
    assign busy       = (state_q != S_IDLE);
    assign cur_layer  = cur_q;
    assign total_out  = par_q.total_out;
    assign total_in   = par_q.total_in;
    assign img_size   = par_q.img_size;
    assign fil_size   = par_q.fil_size;
    assign in_offset  = par_q.in_offset;
    assign out_offset = par_q.out_offset;

endmodule

// File: tb/tb_renkon_layer_sched.sv
// Directed bench for renkon_layer_sched; in_offset expectations follow
// RENKON_SCHED_CHAIN_EN when it is defined for the build.
module tb_renkon_layer_sched;
    import renkon_pkg::*;

    localparam int unsigned LLOG = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_we;
    logic [LLOG-1:0]     cfg_addr;
    logic [LWIDTH-1:0]   cfg_total_out, cfg_total_in, cfg_img_size, cfg_fil_size;
    logic [IMGSIZE-1:0]  cfg_in_offset, cfg_out_offset;
    logic                start;
    logic [LLOG:0]       num_layers;
    logic                abort;
    logic                req;
    logic [LWIDTH-1:0]   total_out, total_in, img_size, fil_size;
    logic [IMGSIZE-1:0]  in_offset, out_offset;
    logic                ack;
    logic                busy, done;
    logic [LLOG-1:0]     cur_layer;

    int n_checks = 0;
    int n_fail   = 0;

    int e_to [3] = '{50, 32, 10};
    int e_ti [3] = '{3, 50, 32};
    int e_is [3] = '{28, 14, 7};
    int e_fs [3] = '{5, 3, 3};
    int e_oo [3] = '{3000, 5000, 6000};
    int t_io [3] = '{100, 1234, 777};
`ifdef RENKON_SCHED_CHAIN_EN
    int e_io [3] = '{100, 3000, 5000};
`else
    int e_io [3] = '{100, 1234, 777};
`endif

    renkon_layer_sched #(
        .LAYER_MAX (8),
        .LAYERLOG  (LLOG)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_total_out  (cfg_total_out),
        .cfg_total_in   (cfg_total_in),
        .cfg_img_size   (cfg_img_size),
        .cfg_fil_size   (cfg_fil_size),
        .cfg_in_offset  (cfg_in_offset),
        .cfg_out_offset (cfg_out_offset),
        .start          (start),
        .num_layers     (num_layers),
        .abort          (abort),
        .req            (req),
        .total_out      (total_out),
        .total_in       (total_in),
        .img_size       (img_size),
        .fil_size       (fil_size),
        .in_offset      (in_offset),
        .out_offset     (out_offset),
        .ack            (ack),
        .busy           (busy),
        .done           (done),
        .cur_layer      (cur_layer)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int to, input int ti, input int is, input int fs,
                      input int io, input int oo);
        cfg_addr       = LLOG'(a);
        cfg_total_out  = LWIDTH'(to);
        cfg_total_in   = LWIDTH'(ti);
        cfg_img_size   = LWIDTH'(is);
        cfg_fil_size   = LWIDTH'(fs);
        cfg_in_offset  = IMGSIZE'(io);
        cfg_out_offset = IMGSIZE'(oo);
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},  32'(req), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_cur"},  32'(cur_layer), 0);
        chk({tag, "_to"},   32'(total_out), 0);
        chk({tag, "_ti"},   32'(total_in), 0);
        chk({tag, "_is"},   32'(img_size), 0);
        chk({tag, "_fs"},   32'(fil_size), 0);
        chk({tag, "_io"},   32'(in_offset), 0);
        chk({tag, "_oo"},   32'(out_offset), 0);
    endtask

    initial begin
        int pulses, dones, busys;
        logic got_done;

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0;
        cfg_total_out = '0; cfg_total_in = '0; cfg_img_size = '0; cfg_fil_size = '0;
        cfg_in_offset = '0; cfg_out_offset = '0;
        start = 1'b0; num_layers = '0; abort = 1'b0; ack = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) wr(i, e_to[i], e_ti[i], e_is[i], e_fs[i], t_io[i], e_oo[i]);

        // Three-layer run, ack 100 cycles after each req
        start = 1'b1; num_layers = 4'd3;
        tick();
        start = 1'b0;
        for (int l = 0; l < 3; l++) begin
            chk("t1_req",  32'(req), 1);
            chk("t1_cur",  32'(cur_layer), 32'(l));
            chk("t1_busy", 32'(busy), 1);
            chk("t1_to",   32'(total_out), 32'(e_to[l]));
            chk("t1_ti",   32'(total_in), 32'(e_ti[l]));
            chk("t1_is",   32'(img_size), 32'(e_is[l]));
            chk("t1_fs",   32'(fil_size), 32'(e_fs[l]));
            chk("t1_io",   32'(in_offset), 32'(e_io[l]));
            chk("t1_oo",   32'(out_offset), 32'(e_oo[l]));
            if (l == 1) begin
                wr(1, 99, 1, 1, 1, 1, 1);
                chk("t1_wr_active_to", 32'(total_out), 32);
            end
            pulses = 0; dones = 0;
            repeat (100) begin
                tick();
                pulses += int'(req);
                dones  += int'(done);
            end
            chk("t1_wait_req",  32'(pulses), 0);
            chk("t1_wait_done", 32'(dones), 0);
            ack = 1'b1;
            tick();
            ack = 1'b0;
            chk("t1_next_req", 32'(req), 0);
            tick();
        end
        chk("t1_done",      32'(done), 1);
        chk("t1_done_busy", 32'(busy), 1);
        chk("t1_done_req",  32'(req), 0);
        tick();
        chk("t1_after_done", 32'(done), 0);
        chk("t1_after_busy", 32'(busy), 0);
        wr(1, e_to[1], e_ti[1], e_is[1], e_fs[1], t_io[1], e_oo[1]);

        // Zero layers: done two cycles after start, no req
        start = 1'b1; num_layers = 4'd0;
        tick();
        start = 1'b0;
        chk("t2_c1_busy", 32'(busy), 1);
        chk("t2_c1_req",  32'(req), 0);
        chk("t2_c1_done", 32'(done), 0);
        tick();
        chk("t2_c2_busy", 32'(busy), 1);
        chk("t2_c2_req",  32'(req), 0);
        chk("t2_c2_done", 32'(done), 1);
        tick();
        chk("t2_c3_busy", 32'(busy), 0);
        chk("t2_c3_done", 32'(done), 0);

        // Abort while waiting on layer 1 of 3
        start = 1'b1; num_layers = 4'd3;
        tick();
        start = 1'b0;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("t3_l1_req", 32'(req), 1);
        chk("t3_l1_cur", 32'(cur_layer), 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_abort_busy", 32'(busy), 0);
        chk("t3_abort_req",  32'(req), 0);
        chk("t3_abort_done", 32'(done), 0);
        ack = 1'b1;
        pulses = 0; dones = 0; busys = 0;
        repeat (6) begin
            tick();
            ack = 1'b0;
            pulses += int'(req);
            dones  += int'(done);
            busys  += int'(busy);
        end
        chk("t3_post_req",  32'(pulses), 0);
        chk("t3_post_done", 32'(dones), 0);
        chk("t3_post_busy", 32'(busys), 0);

        // Restart attempt while busy, then ack held high for 5 cycles
        start = 1'b1; num_layers = 4'd2;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; num_layers = 4'd3;
        tick();
        start = 1'b0;
        chk("t4_restart_req", 32'(req), 0);
        chk("t4_restart_cur", 32'(cur_layer), 0);
        chk("t4_restart_busy", 32'(busy), 1);
        ack = 1'b1;
        pulses = 0;
        repeat (5) begin
            tick();
            pulses += int'(req);
        end
        ack = 1'b0;
        chk("t4_hold_reqs", 32'(pulses), 1);
        chk("t4_hold_cur",  32'(cur_layer), 1);
        chk("t4_hold_busy", 32'(busy), 1);
        chk("t4_hold_done", 32'(done), 0);
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("t4_done", 32'(done), 1);
        tick();
        chk("t4_idle", 32'(busy), 0);

        // num_layers above LAYER_MAX saturates to 8 layers
        start = 1'b1; num_layers = 4'd15;
        tick();
        start = 1'b0;
        pulses = int'(req);
        got_done = 1'b0;
        for (int i = 0; i < 200 && !got_done; i++) begin
            ack = ~ack;
            tick();
            pulses += int'(req);
            if (done) got_done = 1'b1;
        end
        ack = 1'b0;
        chk("t5_sat_reqs", 32'(pulses), 8);
        chk("t5_sat_done", 32'(got_done), 1);
        tick();

        // Reset mid-sequence, then a clean restart
        start = 1'b1; num_layers = 4'd3;
        tick();
        start = 1'b0;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        tick();
        chk("t6_pre_cur", 32'(cur_layer), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("t6_async");
        tick();
        rst = 1'b0;
        tick();
        chk("t6_post_busy", 32'(busy), 0);
        start = 1'b1; num_layers = 4'd3;
        tick();
        start = 1'b0;
        chk("t6_re_req", 32'(req), 1);
        chk("t6_re_cur", 32'(cur_layer), 0);
        chk("t6_re_to",  32'(total_out), 50);
        chk("t6_re_io",  32'(in_offset), 100);
        tick();
        chk("t6_re_wait_req", 32'(req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/renkon_layer_sched.md
RENKON_LAYER_SCHED -- requirements
Module: renkon_layer_sched

Interface
REQ-001 SHALL have parameter LAYER_MAX, default 8: layer-table depth, a power of 2.
REQ-002 SHALL have parameter LAYERLOG, default 3: equal to log2(LAYER_MAX).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cfg_we, input, 1 bit: table write strobe.
REQ-006 SHALL have port cfg_addr, input, LAYERLOG bits: table entry to write.
REQ-007 SHALL have ports cfg_total_out, cfg_total_in, cfg_img_size and cfg_fil_size, inputs, LWIDTH bits each: layer geometry to write.
REQ-008 SHALL have ports cfg_in_offset and cfg_out_offset, inputs, IMGSIZE bits each: image-memory offsets to write.
REQ-009 SHALL have port start, input, 1 bit: run pulse.
REQ-010 SHALL have port num_layers, input, LAYERLOG+1 bits: layer count, sampled with start.
REQ-011 SHALL have port abort, input, 1 bit: stop the sequence.
REQ-012 SHALL have port req, output, 1 bit: one-cycle layer request to renkon_ctrl_core.
REQ-013 SHALL have ports total_out, total_in, img_size and fil_size, outputs, LWIDTH bits each: current layer geometry to the core.
REQ-014 SHALL have ports in_offset and out_offset, outputs, IMGSIZE bits each: current layer offsets to the core.
REQ-015 SHALL have port ack, input, 1 bit: layer-complete indication from the core.
REQ-016 SHALL have ports busy and done, outputs, 1 bit each: busy = sequence running; done = one-cycle completion pulse.
REQ-017 SHALL have port cur_layer, output, LAYERLOG bits: index of the active layer.

Function
REQ-018 SHALL implement the FSM S_IDLE -> S_ISSUE -> S_WAIT -> S_NEXT -> (S_ISSUE | S_DONE) -> S_IDLE.
REQ-019 SHALL, when start is high in S_IDLE with num_layers>0, latch the count, clear cur_layer and enter S_ISSUE on the next edge.
REQ-020 SHALL, in S_ISSUE, load all six parameter outputs from table[cur_layer], assert req for exactly one cycle, and then enter S_WAIT.
REQ-021 SHALL hold the parameter outputs stable from the req cycle until the next S_ISSUE or reset.
REQ-022 SHALL, in S_WAIT, move to S_NEXT on the first cycle ack=1; if ack is held high it SHALL count as one completion.
REQ-023 SHALL, in S_NEXT, increment cur_layer and enter S_ISSUE if the new cur_layer < the latched count, otherwise enter S_DONE.
REQ-024 SHALL, in S_DONE, assert done for one cycle and return to S_IDLE.
REQ-025 SHALL hold busy=1 in every state except S_IDLE.
REQ-026 SHALL place req 1 cycle after start and each subsequent req 2 cycles after the ack that ends the previous layer.
REQ-027 SHALL, for start with num_layers=0, emit done 2 cycles after start with no req.
REQ-028 SHALL saturate num_layers>LAYER_MAX to LAYER_MAX.
REQ-029 SHALL ignore start while busy=1.
REQ-030 SHALL ignore ack in S_IDLE.
REQ-031 SHALL allow cfg_we in any state; a write to the active entry does not affect the outputs already issued.
REQ-032 SHALL, on abort (priority over ack and start), enter S_IDLE next cycle, drop busy, and issue no done and no further req.

Reset
REQ-033 SHALL, with rst=1, immediately force S_IDLE and drive req, busy, done, cur_layer and all parameter outputs to 0, including mid-sequence.
REQ-034 SHALL NOT clear the layer table on reset; its contents after power-up are undefined until written.

Configuration
REQ-035 SHALL, with RENKON_SCHED_CHAIN_EN defined, drive in_offset at each S_ISSUE after the first from the previously issued out_offset, ignoring the table in_offset.
REQ-036 SHALL, without RENKON_SCHED_CHAIN_EN, take in_offset from the table for every layer.

Structure
REQ-037 SHALL take LWIDTH, IMGSIZE and RENKON_LAYER_MAX from the renkon package, which also holds a layer_cfg_t struct (the six fields) used for table entries.
REQ-038 SHALL keep the FSM state typedef local to the module.
REQ-039 SHALL implement the table as sub-module renkon_layer_table: LAYER_MAX x layer_cfg_t register file, one write port, combinational read.

Verification
REQ-040 SHALL be verified: 3 layers written (e.g. total_out 50/32/10), start with num_layers=3, ack 100 cycles after each req -> 3 req pulses with matching params, done once, cur_layer 0,1,2.
REQ-041 SHALL be verified: start with num_layers=0 -> no req, done 2 cycles later, busy high for 2 cycles.
REQ-042 SHALL be verified: abort asserted in S_WAIT of layer 1 of 3 -> busy=0 next cycle, no done, later ack ignored.
REQ-043 SHALL be verified: second start while busy, and ack held high for 5 cycles -> neither restarts nor skips a layer.
REQ-044 SHALL be verified: with CHAIN_EN, out_offset 3000 for layer 0 -> in_offset 3000 for layer 1.
REQ-045 SHALL be verified: rst pulse mid-sequence -> all outputs 0 asynchronously, and a new start then runs normally from layer 0.
